// File: rtl/traffic_pkg.sv
// Shared encodings and default timing for the actuated three-road controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        LAMP_GREEN  = 2'b00,
        LAMP_YELLOW = 2'b01,
        LAMP_RED    = 2'b10
    } lamp_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALLRED = 2'd1,
        ST_GREEN  = 2'd2,
        ST_YELLOW = 2'd3
    } state_t;

    localparam int unsigned GREEN_MIN_DEF = 4;
    localparam int unsigned GREEN_MAX_DEF = 10;
    localparam int unsigned YELLOW_T_DEF  = 3;
    localparam int unsigned ALLRED_T_DEF  = 2;

    // Road index meaning "no road"; also the emg_sel value that disables preemption.
    localparam logic [1:0] NO_ROAD = 2'd3;

    // Lamp colour for one road given the registered state and granted road.
    function automatic lamp_t lamp_of(state_t s, logic [1:0] cur, logic [1:0] road);
        if (road == cur && s == ST_GREEN)  return LAMP_GREEN;
        if (road == cur && s == ST_YELLOW) return LAMP_YELLOW;
        return LAMP_RED;
    endfunction

endpackage

// File: rtl/traffic_rr_pick.sv
// Combinational round-robin picker: first requesting road after `last`.
module traffic_rr_pick
    import traffic_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] base;
    logic [2:0] sum;

    // Search starts at the road following the last granted one (3 treated as 2).
    always_comb begin
        case (last)
            2'd0:    base = 2'd1;
            2'd1:    base = 2'd2;
            default: base = 2'd0;
        endcase
    end

    // Scan the three roads in rotated order and take the first requester.
    always_comb begin
        valid = 1'b0;
        idx   = NO_ROAD;
        sum   = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            sum = 3'(base) + 3'(k);
            if (sum >= 3'd3) sum = sum - 3'd3;
            if (!valid && req[sum[1:0]]) begin
                valid = 1'b1;
                idx   = sum[1:0];
            end
        end
    end

endmodule

// File: rtl/traffic_actuated_ctrl.sv
// Actuated three-road signal controller with emergency preemption and orderly shutdown.
module traffic_actuated_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_MIN = GREEN_MIN_DEF,
    parameter int unsigned GREEN_MAX = GREEN_MAX_DEF,
    parameter int unsigned YELLOW_T  = YELLOW_T_DEF,
    parameter int unsigned ALLRED_T  = ALLRED_T_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] req,
    input  logic       emg,
    input  logic [1:0] emg_sel,
    output logic [1:0] l1,
    output logic [1:0] l2,
    output logic [1:0] l3,
    output logic [1:0] grant,
    output logic       busy
);

    localparam logic [3:0] GMIN_LAST = 4'(GREEN_MIN - 1);
    localparam logic [3:0] GMAX_LAST = 4'(GREEN_MAX - 1);
    localparam logic [3:0] YEL_LAST  = 4'(YELLOW_T - 1);
    localparam logic [3:0] AR_LAST   = 4'(ALLRED_T - 1);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [1:0] cur, cur_n;
    logic [1:0] last, last_n;
    logic       enter;
    logic       emg_v;
    logic       others;
    logic       pick_valid;
    logic [1:0] pick_idx;

    traffic_rr_pick u_pick (
        .req   (req),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // State, dwell counter, granted road and last-granted pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            cur   <= 2'd0;
            last  <= 2'd2;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cur   <= cur_n;
            last  <= last_n;
        end
    end

    // Next-state logic; counters compare with >= so a saturated count still exits.
    always_comb begin
        state_n = state;
        cur_n   = cur;
        last_n  = last;
        enter   = 1'b0;
        emg_v   = emg && (emg_sel != NO_ROAD);
        others  = |(req & ~(3'b001 << cur));
        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_n = ST_ALLRED;
                    enter   = 1'b1;
                end
            end
            ST_ALLRED: begin
                if (cnt >= AR_LAST) begin
                    if (!en) begin
                        state_n = ST_IDLE;
                        enter   = 1'b1;
                    end else if (emg_v) begin
                        state_n = ST_GREEN;
                        cur_n   = emg_sel;
                        enter   = 1'b1;
                    end else if (pick_valid) begin
                        state_n = ST_GREEN;
                        cur_n   = pick_idx;
                        enter   = 1'b1;
                    end
                end
            end
            ST_GREEN: begin
                if (!en) begin
                    state_n = ST_YELLOW;
                    enter   = 1'b1;
                end else if (emg_v) begin
                    if (emg_sel != cur) begin
                        state_n = ST_YELLOW;
                        enter   = 1'b1;
                    end
                end else if (cnt >= GMAX_LAST || (cnt >= GMIN_LAST && others)) begin
                    state_n = ST_YELLOW;
                    enter   = 1'b1;
                end
            end
            ST_YELLOW: begin
                if (cnt >= YEL_LAST) begin
                    state_n = ST_ALLRED;
                    last_n  = cur;
                    enter   = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                enter   = 1'b1;
            end
        endcase
        if (enter)            cnt_n = '0;
        else if (cnt == 4'hF) cnt_n = cnt;
        else                  cnt_n = cnt + 4'd1;
    end

    // Lamp, grant and busy decode from registered state only.
    always_comb begin
        l1    = lamp_of(state, cur, 2'd0);
        l2    = lamp_of(state, cur, 2'd1);
        l3    = lamp_of(state, cur, 2'd2);
        grant = (state == ST_GREEN || state == ST_YELLOW) ? cur : NO_ROAD;
        busy  = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_traffic_actuated_ctrl.sv
// Bench for traffic_actuated_ctrl: directed scenarios plus randomized run against a phase/elapsed-time model.
module tb_traffic_actuated_ctrl;

    localparam int GMIN = 4;
    localparam int GMAX = 10;
    localparam int YT   = 3;
    localparam int ART  = 2;

    localparam logic [1:0] GRN = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] RED = 2'b10;

    localparam int P_IDLE = 0, P_ALLRED = 1, P_GREEN = 2, P_YELLOW = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [2:0] req = '0;
    logic       emg = 1'b0;
    logic [1:0] emg_sel = 2'd3;
    logic [1:0] l1, l2, l3, grant;
    logic       busy;
    logic [8:0] obs;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase, cycles elapsed in phase (unbounded), road shown, last road finished.
    int m_phase, m_el, m_road, m_last;

    traffic_actuated_ctrl #(
        .GREEN_MIN (GMIN),
        .GREEN_MAX (GMAX),
        .YELLOW_T  (YT),
        .ALLRED_T  (ART)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .emg     (emg),
        .emg_sel (emg_sel),
        .l1      (l1),
        .l2      (l2),
        .l3      (l3),
        .grant   (grant),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    assign obs = {l1, l2, l3, grant, busy};

    // Invariant: never more than one non-red lamp.
    always @(negedge clk) begin
        n_cmp++;
        if (int'(l1 != RED) + int'(l2 != RED) + int'(l3 != RED) > 1) begin
            n_bad++;
            $display("FAIL invariant: lamps %b %b %b have more than one non-red", l1, l2, l3);
        end
    end

    function automatic logic [8:0] model_obs();
        logic [1:0] lamp [3];
        logic [1:0] g;
        for (int r = 0; r < 3; r++) lamp[r] = RED;
        g = 2'd3;
        if (m_phase == P_GREEN || m_phase == P_YELLOW) begin
            lamp[m_road] = (m_phase == P_GREEN) ? GRN : YEL;
            g = 2'(m_road);
        end
        return {lamp[0], lamp[1], lamp[2], g, 1'(m_phase != P_IDLE)};
    endfunction

    function automatic int winner();
        if (emg && emg_sel != 2'd3) return int'(emg_sel);
        for (int k = 1; k <= 3; k++)
            if (req[(m_last + k) % 3]) return (m_last + k) % 3;
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_el    = 0;
        m_road  = 0;
        m_last  = 2;
    endtask

    task automatic model_step();
        int  np, nr, nl, w;
        bit  emgv, comp;
        if (rst) begin
            model_reset();
            return;
        end
        np = m_phase; nr = m_road; nl = m_last;
        emgv = emg && (emg_sel != 2'd3);
        comp = 1'b0;
        for (int r = 0; r < 3; r++) if (r != m_road && req[r]) comp = 1'b1;
        case (m_phase)
            P_IDLE:   if (en) np = P_ALLRED;
            P_ALLRED: if (m_el + 1 >= ART) begin
                if (!en) np = P_IDLE;
                else begin
                    w = winner();
                    if (w >= 0) begin np = P_GREEN; nr = w; end
                end
            end
            P_GREEN: begin
                if (!en) np = P_YELLOW;
                else if (emgv) begin
                    if (int'(emg_sel) != m_road) np = P_YELLOW;
                end else if (m_el + 1 >= GMAX || (m_el + 1 >= GMIN && comp)) np = P_YELLOW;
            end
            default: if (m_el + 1 >= YT) begin np = P_ALLRED; nl = m_road; end
        endcase
        m_el    = (np != m_phase) ? 0 : m_el + 1;
        m_phase = np; m_road = nr; m_last = nl;
    endtask

    // Advance model and DUT one clock; inputs must be stable before calling.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; req = '0; emg = 1'b0; emg_sel = 2'd3;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (obs !== {RED, RED, RED, 2'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_async: got %b want %b", obs, {RED, RED, RED, 2'd3, 1'b0});
        end
        en = 1'b1; req = 3'b111;
        for (int k = 0; k < 2; k++) begin
            cycle();
            n_cmp++;
            if (obs !== model_obs()) begin
                n_bad++;
                $display("FAIL reset_held: got %b want %b", obs, model_obs());
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_solo();
        logic [1:0] want;
        do_reset();
        en = 1'b1; req = 3'b001;
        for (int k = 1; k <= 18; k++) begin
            cycle();
            n_cmp++;
            if (obs !== model_obs()) begin
                n_bad++;
                $display("FAIL solo_model k=%0d: got %b want %b", k, obs, model_obs());
            end
            want = (k <= 2) ? RED : (k <= 12) ? GRN : (k <= 15) ? YEL : (k <= 17) ? RED : GRN;
            n_cmp++;
            if (l1 !== want) begin
                n_bad++;
                $display("FAIL solo_l1 k=%0d: got %b want %b", k, l1, want);
            end
        end
    endtask

    task automatic test_contention();
        logic [1:0] want;
        do_reset();
        en = 1'b1; req = 3'b001;
        for (int k = 1; k <= 12; k++) begin
            if (k == 3) req = 3'b011;
            cycle();
            n_cmp++;
            if (obs !== model_obs()) begin
                n_bad++;
                $display("FAIL contention_model k=%0d: got %b want %b", k, obs, model_obs());
            end
            want = (k <= 2) ? RED : (k <= 6) ? GRN : (k <= 9) ? YEL : RED;
            n_cmp++;
            if (l1 !== want) begin
                n_bad++;
                $display("FAIL contention_l1 k=%0d: got %b want %b", k, l1, want);
            end
        end
        n_cmp++;
        if ({l2, grant} !== {GRN, 2'd1}) begin
            n_bad++;
            $display("FAIL contention_l2: got %b want %b", {l2, grant}, {GRN, 2'd1});
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] want;
        do_reset();
        en = 1'b1; req = 3'b111;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            n_cmp++;
            if (obs !== model_obs()) begin
                n_bad++;
                $display("FAIL rr_model k=%0d: got %b want %b", k, obs, model_obs());
            end
            if (k < 3 || (k - 3) % 9 >= 7) want = 2'd3;
            else want = 2'(((k - 3) / 9) % 3);
            n_cmp++;
            if (grant !== want) begin
                n_bad++;
                $display("FAIL rr_grant k=%0d: got %0d want %0d", k, grant, want);
            end
        end
    endtask

    task automatic test_preempt();
        logic [8:0] want;
        do_reset();
        en = 1'b1; req = 3'b001;
        for (int k = 0; k < 4; k++) cycle();
        emg = 1'b1; emg_sel = 2'd2;
        for (int j = 1; j <= 26; j++) begin
            if (j == 26) emg = 1'b0;
            cycle();
            n_cmp++;
            if (obs !== model_obs()) begin
                n_bad++;
                $display("FAIL preempt_model j=%0d: got %b want %b", j, obs, model_obs());
            end
            if (j <= 3)       want = {YEL, RED, RED, 2'd0, 1'b1};
            else if (j <= 5)  want = {RED, RED, RED, 2'd3, 1'b1};
            else if (j <= 25) want = {RED, RED, GRN, 2'd2, 1'b1};
            else              want = {RED, RED, YEL, 2'd2, 1'b1};
            n_cmp++;
            if (obs !== want) begin
                n_bad++;
                $display("FAIL preempt_seq j=%0d: got %b want %b", j, obs, want);
            end
        end
    endtask

    task automatic test_shutdown();
        logic [8:0] want;
        do_reset();
        en = 1'b1; req = 3'b001;
        for (int k = 0; k < 5; k++) cycle();
        en = 1'b0; emg = 1'b1; emg_sel = 2'd1;
        for (int j = 1; j <= 8; j++) begin
            cycle();
            n_cmp++;
            if (obs !== model_obs()) begin
                n_bad++;
                $display("FAIL shutdown_model j=%0d: got %b want %b", j, obs, model_obs());
            end
            if (j <= 3)      want = {YEL, RED, RED, 2'd0, 1'b1};
            else if (j <= 5) want = {RED, RED, RED, 2'd3, 1'b1};
            else             want = {RED, RED, RED, 2'd3, 1'b0};
            n_cmp++;
            if (obs !== want) begin
                n_bad++;
                $display("FAIL shutdown_seq j=%0d: got %b want %b", j, obs, want);
            end
        end
        emg = 1'b0; emg_sel = 2'd3;
    endtask

    task automatic test_reset_mid_yellow();
        do_reset();
        en = 1'b1; req = 3'b011;
        for (int k = 0; k < 8; k++) cycle();
        n_cmp++;
        if (l1 !== YEL) begin
            n_bad++;
            $display("FAIL midyel_pre: got l1=%b want %b", l1, YEL);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (obs !== {RED, RED, RED, 2'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL midyel_async: got %b want %b", obs, {RED, RED, RED, 2'd3, 1'b0});
        end
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_cmp++;
            if (obs !== model_obs()) begin
                n_bad++;
                $display("FAIL midyel_after k=%0d: got %b want %b", k, obs, model_obs());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0)  req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) emg = ~emg;
            if ($urandom_range(0, 7) == 0)  emg_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 40) == 0) en = ~en;
            if (k % 100 == 99) en = 1'b1;
            cycle();
            n_cmp++;
            if (obs !== model_obs()) begin
                n_bad++;
                $display("FAIL random k=%0d: got %b want %b (req=%b emg=%b sel=%0d en=%b)",
                         k, obs, model_obs(), req, emg, emg_sel, en);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_solo();
        test_contention();
        test_round_robin();
        test_preempt();
        test_shutdown();
        test_reset_mid_yellow();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_actuated_ctrl.md
TRAFFIC_ACTUATED_CTRL -- requirements
Module: traffic_actuated_ctrl

Interface
REQ-001 Parameter GREEN_MIN, default 4, minimum green dwell in cycles (legal range 1..15).
REQ-002 Parameter GREEN_MAX, default 10, maximum green dwell in cycles (GREEN_MIN..15).
REQ-003 Parameter YELLOW_T, default 3, yellow dwell in cycles (1..15).
REQ-004 Parameter ALLRED_T, default 2, all-red clearance dwell in cycles (1..15).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 en  input  1  level enable; 0 requests an orderly shutdown to all-red idle.
REQ-008 req  input  3  per-road vehicle sensor, level; bit i = road i+1 has demand.
REQ-009 emg  input  1  emergency preemption request, level.
REQ-010 emg_sel  input  2  road index (0..2) to preempt for; value 3 makes emg ignored.
REQ-011 l1, l2, l3  output  2 each  road lamps: green=00, yellow=01, red=10.
REQ-012 grant  output  2  index of the road currently green or yellow; 3 when none.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, ALLRED, GREEN, YELLOW; one 4-bit dwell counter cleared on every state entry, incremented otherwise.
REQ-015 A state of dwell N shall last exactly N cycles: exit is evaluated when the counter equals N-1.
REQ-016 IDLE: all lamps red, grant=3; en=1 moves to ALLRED on the next edge.
REQ-017 ALLRED: all lamps red; after ALLRED_T cycles, if a winner exists go GREEN for it, else remain in ALLRED (counter saturates) until a request arrives.
REQ-018 Winner selection: a valid emg (emg=1, emg_sel!=3) wins outright; otherwise round-robin over req starting at the road after the last granted road (after reset, road 0 has top priority).
REQ-019 GREEN: the granted lamp is green and the others red; grant holds the road index.
REQ-020 GREEN exits to YELLOW when counter>=GREEN_MIN-1 and any other road's req is 1, or when counter==GREEN_MAX-1, whichever occurs first.
REQ-021 With no competing request, green is held only up to GREEN_MAX, then the cycle continues through YELLOW and ALLRED; the same road may be re-granted.
REQ-022 YELLOW: the granted lamp is yellow; after YELLOW_T cycles go to ALLRED; the last-granted pointer updates on YELLOW exit.
REQ-023 Preemption: a valid emg for a different road, seen while in GREEN, forces YELLOW on the next edge, overriding GREEN_MIN.
REQ-024 Preemption for the road already green holds GREEN indefinitely, with no GREEN_MAX limit, while emg stays valid; on release the normal GREEN_MIN/GREEN_MAX rules resume with the current count.
REQ-025 Preemption never shortens YELLOW or ALLRED; clearance always completes.
REQ-026 en=0 in GREEN forces YELLOW on the next edge; YELLOW then completes, ALLRED completes, then IDLE. en=0 in ALLRED completes ALLRED_T, then IDLE.
REQ-027 en=0 overrides emg; en returning to 1 before IDLE is reached cancels the shutdown.
REQ-028 Simultaneous GREEN_MAX expiry and competing request produce a single transition to YELLOW.
REQ-029 At most one lamp shall be non-red in any cycle; this is an invariant.
REQ-030 Outputs shall be decoded combinationally from the registered state and grant only, with no input-to-output paths.

Reset
REQ-031 rst=1 shall force IDLE, counter=0, last-granted=2 (so road 0 is next), l1=l2=l3=red, grant=3, busy=0, regardless of the clock.
REQ-032 Reset asserted mid-GREEN shall immediately show all-red, with no yellow.

Structure
REQ-033 Package traffic_pkg shall hold the lamp encodings (green/yellow/red), the FSM state encoding, and the default timing constants.
REQ-034 Sub-module traffic_rr_pick shall be combinational: inputs req[2:0] and last[1:0], outputs valid and idx[1:0]; the round-robin function lives here only.

Verification
REQ-035 Reset, then en=1, req=001: IDLE to ALLRED for 2 cycles, l1 green for 10 cycles, l1 yellow for 3 cycles, ALLRED for 2 cycles, l1 green again.
REQ-036 Road 0 green and req=011 from cycle 0 of GREEN: l1 green exactly 4 cycles, yellow 3, all-red 2, then l2 green with grant=1.
REQ-037 req=111 held: grants cycle 0, 1, 2, 0 in order, each green lasting 4 cycles.
REQ-038 Road 0 green at cycle 1, emg=1 and emg_sel=2: yellow on the next edge, 3 yellow and 2 all-red cycles, then l3 green held for 20 cycles while emg stays high.
REQ-039 en dropped mid-GREEN: yellow 3 cycles, all-red 2 cycles, IDLE with busy=0; emg=1 during this sequence has no effect.
REQ-040 rst pulsed mid-YELLOW without a clock edge: all lamps red and grant=3 immediately; the one-non-red-lamp invariant is asserted in every test.
